rng_sample_ctrl: RTL and testbench
==================================

# rng_sample_ctrl

Sequencing controller for the entropy-sampling path of the random number generator. Generates a programmable sample strobe from the system clock and samples a raw entropy bit on each strobe. Packs accepted bits into bytes and hands them to the UART side over a valid/ready handshake. Runs either a fixed-length burst of bytes or continuously until stopped.

## Interface
- `DIV_BIT`, 8: width of the sample divisor.
- `CNT_BIT`, 16: width of the burst byte count.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `i_Start` in 1: start a run; sampled only in IDLE.
- `i_Stop` in 1: abort the run; any cycle.
- `i_Div` in DIV_BIT: strobe period in clk cycles; 0 is treated as 1; latched at start.
- `i_Burst` in CNT_BIT: bytes per run; 0 means continuous; latched at start.
- `i_Raw_Bit` in 1: entropy bit, already synchronized to clk.
- `i_Ready` in 1: consumer ready.
- `o_Data` out 8: output byte; reset 8'h00.
- `o_Valid` out 1: `o_Data` valid; reset 0.
- `o_Busy` out 1: high in COLLECT and DRAIN; reset 0.
- `o_Done` out 1: one-cycle pulse at run end; reset 0.
- `o_Sample_Strobe` out 1: one-cycle sample pulse; reset 0.
- `o_Overrun` out 1: sticky byte-dropped flag; reset 0, cleared on accepted start.

## Operation
- **States:** IDLE, COLLECT, DRAIN.
- **IDLE → COLLECT:** on `i_Start & ~i_Stop`.
  - Latch `max(i_Div,1)` and `i_Burst`.
  - Clear the divider counter, bit counter, shift register, byte counter and `o_Overrun`.
  - `i_Start` outside IDLE is ignored.
- **Divider:** the counter runs 0..D-1 in COLLECT only. `o_Sample_Strobe`=1 in the cycle the counter is D-1, then the counter wraps to 0.
- **Bit acceptance:** each strobe accepts `i_Raw_Bit` into the shift register. The register shifts left and the new bit enters bit 0, so the first accepted bit ends as the byte MSB.
- **Byte completion:** the 8th accepted bit completes a byte, and the bit counter wraps to 0.
  - If `o_Valid`=0, or a transfer (`o_Valid & i_Ready`) occurs in the same cycle: load `o_Data`, keep `o_Valid`=1 and increment the byte counter.
  - Otherwise: drop the byte and set `o_Overrun`=1. The byte counter is unchanged.
- **Handshake:**
  - A transfer occurs when `o_Valid & i_Ready`.
  - `o_Data` is held stable while `o_Valid & ~i_Ready`.
  - `o_Valid` clears after a transfer unless a new byte loads in the same cycle.
- **Burst end:** when the byte counter reaches a nonzero burst value, go to DRAIN. No further strobes are generated.
- **Stop:** `i_Stop` in COLLECT goes to DRAIN next cycle and discards partial shift-register bits.
  - A byte completing in that same cycle is still loaded under the normal rules.
  - `i_Stop` in IDLE or DRAIN has no effect.
- **DRAIN → IDLE:** once `o_Valid`=0, pulse `o_Done` for one cycle and return to IDLE.
- **Width rules:** the byte counter is CNT_BIT wide and compares for equality, so `i_Burst`=2^CNT_BIT-1 is legal. In continuous mode the counter wraps freely.
- **Reset:** `reset` in any state, including mid-run, returns to IDLE with all outputs at their reset values next edge. The pending byte is lost.

## Timing
- Start accepted at edge N; COLLECT from cycle N+1.
- First strobe in cycle N+D; subsequent strobes every D cycles.
- `o_Valid` rises the cycle after the strobe that accepts the 8th bit.
- Without debias, first `o_Valid` is at cycle N+8D+1.
- Last byte loaded → DRAIN the next cycle. `o_Done` is asserted the cycle after the first DRAIN cycle with `o_Valid`=0. Minimum DRAIN-to-done is 1 cycle.
- `o_Busy` equals (state != IDLE), registered.
- Throughput: one byte per 8D cycles without debias. No bubbles if `i_Ready` is held high.

## Configuration
- Macro: `RNG_SAMPLE_VN_DEBIAS_EN`.
- **Defined:** von Neumann debiasing. Strobes are taken in pairs (a, b), with a pair-phase flag cleared at start.
  - Pair 10 accepts 1; pair 01 accepts 0; pairs 00 and 11 accept nothing.
  - Acceptance happens on the second strobe of the pair.
  - Stop discards a half pair.
- **Undefined:** every strobe accepts `i_Raw_Bit`. The pair logic is absent.

## Test plan
- **Basic byte:** `i_Div`=4, `i_Burst`=1, `i_Ready`=1, `i_Raw_Bit` pattern 1,0,1,1,0,0,1,0 on successive strobes, no debias.
  - Required: `o_Data`=8'hB2; `o_Valid` for 1 cycle at start+33.
  - Then `o_Done` pulses and `o_Busy` falls.
- **Backpressure overrun:** `i_Div`=1, `i_Burst`=0, `i_Ready`=0 for 20 cycles.
  - Required: first byte held stable; second byte dropped; `o_Overrun`=1.
  - Raising `i_Ready` transfers the first byte.
- **Stop mid-byte:** `i_Div`=2, Stop after 5 accepted bits with no byte pending.
  - Required: DRAIN then `o_Done` 2 cycles after the stop edge; no `o_Valid`.
- **Div zero / burst count:** `i_Div`=0, `i_Burst`=3, `i_Ready`=1.
  - Required: strobe every cycle; exactly 3 transfers; `o_Done` once.
  - A start during the run is ignored.
- **Reset mid-run:** `reset`=1 while `o_Valid`=1 and `i_Ready`=0.
  - Required: next cycle all outputs are 0 and the state is IDLE.
- **Debias (macro defined):** raw pairs 11, 10, 00, 01 repeated ×4, `i_Div`=1.
  - Required: `o_Data`=8'hAA after 32 strobes.

Source files
------------

// File: rtl/rng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rng_sample_ctrl
// Purpose  : Entropy-sampling sequencer. Produces a programmable sample strobe,
//            accepts one raw entropy bit per strobe, packs accepted bits
//            MSB-first into bytes, and offers each byte over a valid/ready
//            handshake. A run is either a fixed number of bytes or continuous
//            until stopped.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in  system clock
//   reset           in  synchronous active-high reset
//   i_Start         in  start a run (honoured in IDLE only, not with i_Stop)
//   i_Stop          in  abort the collect phase
//   i_Div           in  strobe period in clk cycles (0 behaves as 1)
//   i_Burst         in  bytes per run (0 = continuous)
//   i_Raw_Bit       in  entropy bit, synchronous to clk
//   i_Ready         in  consumer ready
//   o_Data          out output byte
//   o_Valid         out o_Data valid
//   o_Busy          out run in progress (COLLECT or DRAIN)
//   o_Done          out one-cycle pulse at end of run
//   o_Sample_Strobe out one-cycle sample pulse
//   o_Overrun       out sticky: a completed byte was dropped
// Build option
//   RNG_SAMPLE_VN_DEBIAS_EN : when defined, strobes are taken in pairs and
//                             von Neumann debiased (10 -> 1, 01 -> 0).
// ============================================================================
module rng_sample_ctrl #(
  parameter int DIV_BIT = 8,
  parameter int CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_Start,
  input  logic               i_Stop,
  input  logic [DIV_BIT-1:0] i_Div,
  input  logic [CNT_BIT-1:0] i_Burst,
  input  logic               i_Raw_Bit,
  input  logic               i_Ready,
  output logic [7:0]         o_Data,
  output logic               o_Valid,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Sample_Strobe,
  output logic               o_Overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam logic [DIV_BIT-1:0] c_div_one = DIV_BIT'(1);
  localparam logic [CNT_BIT-1:0] c_cnt_one = CNT_BIT'(1);

  logic [1:0]         state_q,    state_d;
  logic [DIV_BIT-1:0] div_q,      div_d;
  logic [DIV_BIT-1:0] div_cnt_q,  div_cnt_d;
  logic [CNT_BIT-1:0] burst_q,    burst_d;
  logic [CNT_BIT-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]         bit_cnt_q,  bit_cnt_d;
  // Only the seven oldest bits need storing; the eighth arrives with the strobe.
  logic [6:0]         shift_q,    shift_d;
  logic [7:0]         data_q,     data_d;
  logic               valid_q,    valid_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               ovr_q,      ovr_d;

  logic w_strobe;
  logic w_accept;
  logic w_bit;
  logic w_xfer;
  logic w_byte_done;
  logic w_load;

  // Counter only advances in COLLECT, so the strobe cannot fire elsewhere.
  assign w_strobe = (state_q == S_COLLECT) && (div_cnt_q == (div_q - c_div_one));
  assign w_xfer   = valid_q & i_Ready;

`ifdef RNG_SAMPLE_VN_DEBIAS_EN
  logic pair_q,  pair_d;   // 1 = first half of a pair has been captured
  logic first_q, first_d;  // first bit of the current pair

  // A bit is produced on the second strobe of a pair, and only if it differs
  // from the first; the first bit is the output value (10 -> 1, 01 -> 0).
  assign w_accept = w_strobe & pair_q & (first_q ^ i_Raw_Bit);
  assign w_bit    = first_q;
`else
  assign w_accept = w_strobe;
  assign w_bit    = i_Raw_Bit;
`endif

  assign w_byte_done = w_accept && (bit_cnt_q == 3'd7);
  // A completed byte lands only if the output slot is empty or emptying now.
  assign w_load      = w_byte_done && (!valid_q || w_xfer);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    burst_d    = burst_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ovr_d      = ovr_q;
    done_d     = 1'b0;
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
    pair_d     = pair_q;
    first_d    = first_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_Start && !i_Stop) begin
          state_d    = S_COLLECT;
          div_d      = (i_Div == '0) ? c_div_one : i_Div;
          burst_d    = i_Burst;
          div_cnt_d  = '0;
          byte_cnt_d = '0;
          bit_cnt_d  = 3'd0;
          shift_d    = 7'd0;
          ovr_d      = 1'b0;
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
          pair_d     = 1'b0;
`endif
        end
      end

      S_COLLECT: begin
        div_cnt_d = w_strobe ? '0 : (div_cnt_q + c_div_one);
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
        if (w_strobe) begin
          pair_d = ~pair_q;
          if (!pair_q) first_d = i_Raw_Bit;
        end
`endif
        if (w_accept) begin
          shift_d   = {shift_q[5:0], w_bit};
          bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 on the 8th bit
        end
        if (w_byte_done && !w_load) ovr_d = 1'b1;
        if (w_load) byte_cnt_d = byte_cnt_q + c_cnt_one;

        if (i_Stop || (w_load && (burst_q != '0) && (byte_cnt_d == burst_q))) begin
          state_d   = S_DRAIN;
          // Partial bits (and any half pair) are meaningless after the run.
          bit_cnt_d = 3'd0;
          shift_d   = 7'd0;
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
          pair_d    = 1'b0;
`endif
        end
      end

      S_DRAIN: begin
        if (!valid_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    valid_d = w_load ? 1'b1 : (valid_q & ~i_Ready);
    data_d  = w_load ? {shift_q, w_bit} : data_q;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= c_div_one;
      div_cnt_q  <= '0;
      burst_q    <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
      pair_q     <= 1'b0;
      first_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      burst_q    <= burst_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
      pair_q     <= pair_d;
      first_q    <= first_d;
`endif
    end
  end

  assign o_Data          = data_q;
  assign o_Valid         = valid_q;
  assign o_Busy          = busy_q;
  assign o_Done          = done_q;
  assign o_Sample_Strobe = w_strobe;
  assign o_Overrun       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_rng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_sample_ctrl
// Purpose  : Self-checking bench for rng_sample_ctrl. Each run is described
//            by per-cycle stimulus arrays (raw bit, ready, stop, start); a
//            behavioural model derives strobe times, accepted bits, byte
//            handshake and run end from the block's rules, and every output
//            is compared each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_sample_ctrl;

  localparam int MAXC = 460;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Start, i_Stop, i_Raw_Bit, i_Ready;
  logic [7:0]  i_Div;
  logic [15:0] i_Burst;
  logic [7:0]  o_Data;
  logic        o_Valid, o_Busy, o_Done, o_Sample_Strobe, o_Overrun;

  always #5 clk = ~clk;

  rng_sample_ctrl #(.DIV_BIT(8), .CNT_BIT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_Start         (i_Start),
    .i_Stop          (i_Stop),
    .i_Div           (i_Div),
    .i_Burst         (i_Burst),
    .i_Raw_Bit       (i_Raw_Bit),
    .i_Ready         (i_Ready),
    .o_Data          (o_Data),
    .o_Valid         (o_Valid),
    .o_Busy          (o_Busy),
    .o_Done          (o_Done),
    .o_Sample_Strobe (o_Sample_Strobe),
    .o_Overrun       (o_Overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle stimulus of one run; index = cycles after the start cycle.
  bit raw_a [MAXC];
  bit rdy_a [MAXC];
  bit stp_a [MAXC];
  bit sta_a [MAXC];

  // Model state that persists between runs.
  logic [7:0] m_data = 8'h00;
  bit         m_ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int t = 0; t < MAXC; t++) begin
      raw_a[t] = 1'b0; rdy_a[t] = 1'b1; stp_a[t] = 1'b0; sta_a[t] = 1'b0;
    end
  endtask

  task automatic check_all_idle_zero(input string tag);
    check({tag, " data"},   32'(o_Data), 32'h0);
    check({tag, " valid"},  32'(o_Valid), 32'h0);
    check({tag, " busy"},   32'(o_Busy), 32'h0);
    check({tag, " done"},   32'(o_Done), 32'h0);
    check({tag, " strobe"}, 32'(o_Sample_Strobe), 32'h0);
    check({tag, " ovr"},    32'(o_Overrun), 32'h0);
  endtask

  // One run: start in cycle 0, then ncyc checked cycles. A stop is always
  // forced near the end (with ready high) so the block is idle afterwards.
  task automatic run(input string name, input int div_in, input int burst, input int ncyc);
    int         d, nbits, bytes;
    bit         coll, drain, valid, done, strobe, xfer, acc, abit, load, nvalid, ndone;
    bit         pair, first;
    logic [7:0] sh, nb;

    for (int t = ncyc - 10; t <= ncyc; t++) rdy_a[t] = 1'b1;
    stp_a[ncyc - 6] = 1'b1;

    d = (div_in == 0) ? 1 : div_in;
    i_Div = 8'(div_in); i_Burst = 16'(burst);
    i_Start = 1'b1; i_Stop = 1'b0; i_Ready = rdy_a[0]; i_Raw_Bit = raw_a[0];
    @(posedge clk); #1;

    coll = 1'b1; drain = 1'b0; valid = 1'b0; done = 1'b0;
    nbits = 0; bytes = 0; sh = 8'h00; pair = 1'b0; first = 1'b0; m_ovr = 1'b0;

    for (int t = 1; t <= ncyc; t++) begin
      i_Start = sta_a[t]; i_Stop = stp_a[t]; i_Ready = rdy_a[t]; i_Raw_Bit = raw_a[t];
      // Config inputs wander during the run; only start-time values matter.
      i_Div = 8'($urandom); i_Burst = 16'($urandom);
      @(negedge clk);

      strobe = coll && (t % d == 0);
      check($sformatf("%s t=%0d strobe", name, t), 32'(o_Sample_Strobe), 32'(strobe));
      check($sformatf("%s t=%0d valid",  name, t), 32'(o_Valid), 32'(valid));
      check($sformatf("%s t=%0d data",   name, t), 32'(o_Data), 32'(m_data));
      check($sformatf("%s t=%0d busy",   name, t), 32'(o_Busy), 32'(coll || drain));
      check($sformatf("%s t=%0d done",   name, t), 32'(o_Done), 32'(done));
      check($sformatf("%s t=%0d ovr",    name, t), 32'(o_Overrun), 32'(m_ovr));

      xfer = valid && rdy_a[t];
      acc = 1'b0; abit = 1'b0; load = 1'b0; nb = sh;
      if (strobe) begin
`ifdef RNG_SAMPLE_VN_DEBIAS_EN
        if (!pair) begin
          first = raw_a[t]; pair = 1'b1;
        end else begin
          pair = 1'b0;
          if (first != raw_a[t]) begin acc = 1'b1; abit = first; end
        end
`else
        acc = 1'b1; abit = raw_a[t];
`endif
      end
      if (acc) begin
        nb = {sh[6:0], abit};
        sh = nb;
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (!valid || xfer) load = 1'b1;
          else m_ovr = 1'b1;
        end
      end
      nvalid = load ? 1'b1 : (valid && !xfer);
      if (load) begin
        m_data = nb;
        bytes  = (bytes + 1) % 65536;
      end
      ndone = drain && !valid;
      if (drain && !valid) drain = 1'b0;
      else if (coll && (stp_a[t] || (load && burst != 0 && bytes == burst))) begin
        coll = 1'b0; drain = 1'b1;
      end
      valid = nvalid;
      done  = ndone;
      @(posedge clk); #1;
    end
    i_Start = 1'b0; i_Stop = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] dbs;

    reset = 1'b1; i_Start = 1'b0; i_Stop = 1'b0; i_Raw_Bit = 1'b0;
    i_Ready = 1'b0; i_Div = 8'd0; i_Burst = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_idle_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic byte: D=4, burst 1, pattern 1,0,1,1,0,0,1,0 on successive strobes.
    clear_stim();
    pat = 8'hB2;
    for (int t = 1; t <= 32; t++) raw_a[t] = pat[7 - (t - 1) / 4];
    run("basic", 4, 1, 45);
`ifndef RNG_SAMPLE_VN_DEBIAS_EN
    check("basic final data", 32'(o_Data), 32'hB2);
`endif

    // Backpressure: continuous, D=1, ready low for 20 cycles.
    clear_stim();
    for (int t = 0; t < MAXC; t++) raw_a[t] = 1'($urandom);
    for (int t = 1; t <= 20; t++) rdy_a[t] = 1'b0;
    run("overrun", 1, 0, 40);
`ifndef RNG_SAMPLE_VN_DEBIAS_EN
    check("overrun sticky", 32'(o_Overrun), 32'h1);
`endif

    // Stop after 5 accepted bits (strobes at 2,4,6,8,10), nothing pending.
    clear_stim();
    for (int t = 0; t < MAXC; t++) raw_a[t] = 1'($urandom);
    stp_a[11] = 1'b1;
    run("stop", 2, 0, 30);

    // Divisor 0 acts as 1; burst of 3; stray starts mid-run are ignored.
    clear_stim();
    for (int t = 0; t < MAXC; t++) raw_a[t] = 1'($urandom);
    for (int t = 2; t <= 20; t++) sta_a[t] = ($urandom_range(0, 2) == 0);
    run("div0", 0, 3, 40);

`ifdef RNG_SAMPLE_VN_DEBIAS_EN
    // Raw pairs 11,10,00,01 repeated: accepted 1,0,1,0,... -> 8'hAA.
    clear_stim();
    dbs = 8'b1110_0001;
    for (int t = 1; t <= 32; t++) raw_a[t] = dbs[7 - ((t - 1) % 8)];
    run("debias", 1, 1, 45);
    check("debias final data", 32'(o_Data), 32'hAA);
`endif

    // Randomised runs: divisor, burst, ready, raw bits and stray starts.
    for (int r = 0; r < 5; r++) begin
      clear_stim();
      for (int t = 0; t < MAXC; t++) begin
        raw_a[t] = 1'($urandom);
        rdy_a[t] = ($urandom_range(0, 3) != 0);
      end
      for (int t = 2; t <= 8; t++) sta_a[t] = ($urandom_range(0, 3) == 0);
      run($sformatf("rand%0d", r), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 200);
    end

    // Reset mid-run with a byte pending and the consumer stalled.
    clear_stim();
    i_Div = 8'd1; i_Burst = 16'd0; i_Ready = 1'b0; i_Stop = 1'b0;
    i_Start = 1'b1; i_Raw_Bit = 1'($urandom);
    @(posedge clk); #1;
    i_Start = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      i_Raw_Bit = 1'($urandom);
      @(posedge clk); #1;
    end
`ifndef RNG_SAMPLE_VN_DEBIAS_EN
    @(negedge clk);
    check("pre-reset valid", 32'(o_Valid), 32'h1);
    #1;
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_idle_zero("midreset");
    #1;
    reset = 1'b0;
    m_data = 8'h00; m_ovr = 1'b0;
    @(posedge clk); #1;

    // Fresh run after the reset.
    clear_stim();
    for (int t = 0; t < MAXC; t++) raw_a[t] = 1'($urandom);
    run("post_reset", 3, 2, 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
